// File: rtl/memwb_stage.sv
// Memory and writeback pipeline stages: the M register, a req/ack data-memory
// handshake with store lane formatting and load extension, and the W register feeding decode.
module memwb_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ValidE,
   input  logic                  RegWriteE,
   input  logic                  MemWriteE,
   input  logic [1:0]            ResultSrcE,
   input  logic [4:0]            RdE,
   input  logic [2:0]            funct3E,
   input  logic [DATA_WIDTH-1:0] ALUResultE,
   input  logic [DATA_WIDTH-1:0] WriteDataE,
   input  logic [DATA_WIDTH-1:0] PCPlus4E,
   output logic                  StallM,
   output logic                  DMemReq,
   output logic                  DMemWe,
   output logic [DATA_WIDTH-1:0] DMemAddr,
   output logic [DATA_WIDTH-1:0] DMemWData,
   output logic [3:0]            DMemByteEn,
   input  logic [DATA_WIDTH-1:0] DMemRData,
   input  logic                  DMemAck,
   output logic                  RegWriteW,
   output logic [4:0]            RdW,
   output logic [DATA_WIDTH-1:0] ResultW,
   output logic                  MisalignW
);

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_next;

   logic                  ValidM, RegWriteM, MemWriteM;
   logic [1:0]            ResultSrcM;
   logic [4:0]            RdM;
   logic [2:0]            funct3M;
   logic [DATA_WIDTH-1:0] ALUResultM, WriteDataM, PCPlus4M;

   logic                  RegWriteWr;
   logic [1:0]            ResultSrcW;
   logic [DATA_WIDTH-1:0] ALUResultW, LoadDataW, PCPlus4W;

   logic                  memop_m, misalign_m;
   logic [1:0]            addr_lo;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] load_data;

   // M register: a bubble clears every enable so nothing downstream fires
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ValidM     <= 1'b0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
         RdM        <= '0;
         funct3M    <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
      end else if (!StallM) begin
         ValidM     <= ValidE;
         RegWriteM  <= ValidE & RegWriteE;
         MemWriteM  <= ValidE & MemWriteE;
         ResultSrcM <= ResultSrcE;
         RdM        <= RdE;
         funct3M    <= funct3E;
         ALUResultM <= ALUResultE;
         WriteDataM <= WriteDataE;
         PCPlus4M   <= PCPlus4E;
      end
   end

   assign addr_lo    = ALUResultM[1:0];
   assign memop_m    = ValidM & (MemWriteM | (ResultSrcM == 2'b01));
   assign misalign_m = ((funct3M[1:0] == 2'b01) & addr_lo[0]) |
                       ((funct3M[1:0] == 2'b10) & (addr_lo != 2'b00));

   assign DMemReq  = memop_m & ~misalign_m & ((state == IDLE) | (state == WAIT));
   assign StallM   = DMemReq & ~DMemAck;
   assign DMemWe   = DMemReq & MemWriteM;
   assign DMemAddr = {ALUResultM[31:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (DMemReq && !DMemAck) state_next = WAIT;
         WAIT: if (DMemReq && DMemAck)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      DMemWData  = '0;
      DMemByteEn = 4'b0000;
      case (funct3M[1:0])
         2'b00: begin
            DMemWData  = {4{WriteDataM[7:0]}};
            DMemByteEn = 4'b0001 << addr_lo;
         end
         2'b01: begin
            DMemWData  = {2{WriteDataM[15:0]}};
            DMemByteEn = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            DMemWData  = WriteDataM;
            DMemByteEn = 4'b1111;
         end
      endcase
      if (!DMemWe) DMemByteEn = 4'b0000;
   end

   always_comb begin
      ld_byte   = '0;
      load_data = DMemRData;
      case (addr_lo)
         2'b00: ld_byte = DMemRData[7:0];
         2'b01: ld_byte = DMemRData[15:8];
         2'b10: ld_byte = DMemRData[23:16];
         default: ld_byte = DMemRData[31:24];
      endcase
      ld_half = addr_lo[1] ? DMemRData[31:16] : DMemRData[15:0];
      case (funct3M)
         3'b000: load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001: load_data = {{16{ld_half[15]}}, ld_half};
         3'b100: load_data = {24'h0, ld_byte};
         3'b101: load_data = {16'h0, ld_half};
         default: load_data = DMemRData;
      endcase
   end

   // A stalled M loads a bubble into W so each instruction writes back once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteWr <= 1'b0;
         MisalignW  <= 1'b0;
         RdW        <= '0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         LoadDataW  <= '0;
         PCPlus4W   <= '0;
      end else if (StallM) begin
         RegWriteWr <= 1'b0;
         MisalignW  <= 1'b0;
         RdW        <= '0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         LoadDataW  <= '0;
         PCPlus4W   <= '0;
      end else begin
         RegWriteWr <= RegWriteM & ~(memop_m & misalign_m);
         MisalignW  <= memop_m & misalign_m;
         RdW        <= RdM;
         ResultSrcW <= ResultSrcM;
         ALUResultW <= ALUResultM;
         LoadDataW  <= load_data;
         PCPlus4W   <= PCPlus4M;
      end
   end

   assign RegWriteW = RegWriteWr & (RdW != 5'd0);

   always_comb begin
      case (ResultSrcW)
         2'b01:   ResultW = LoadDataW;
         2'b10:   ResultW = PCPlus4W;
         default: ResultW = ALUResultW;
      endcase
   end

endmodule
